// File: rtl/rx_uart_pkg.sv
// Shared definitions for the 7E2 UART receiver: FSM state encoding and frame constants.
package rx_uart_pkg;

    localparam int DATA_BITS            = 7;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

    // Encoding is visible on current_state, so the values are fixed.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

endpackage

// File: rtl/rx_synchroniser.sv
// Multi-flop synchroniser for the asynchronous serial line; flops reset to the idle level (1).
module rx_synchroniser #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_reg[STAGES-1];

endmodule

// File: rtl/rx_uart_receiver.sv
// UART receiver: start bit, 7 data bits LSB first, even parity, STOP_BITS stop bits.
// Define RX_PARITY_CHECK_EN to check parity; otherwise the parity bit is consumed and parity_err is 0.
module rx_uart_receiver
    import rx_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic [2:0]           current_state
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    logic                 rx_sync;
    logic                 rx_prev_reg;
    rx_state_t            state_reg;
    logic [CNT_W-1:0]     baud_cnt_reg;
    logic [2:0]           bit_cnt_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 stop_err_reg;
    logic                 bit_tick;

`ifdef RX_PARITY_CHECK_EN
    logic                 parity_bit_reg;
    logic                 parity_err_reg;
    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    rx_synchroniser #(
        .STAGES   (2)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (rx_in),
        .sync_out (rx_sync)
    );

    assign bit_tick      = (baud_cnt_reg == BIT_LAST);
    assign current_state = state_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            rx_prev_reg    <= 1'b1;
            baud_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            stop_err_reg   <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            frame_err      <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            parity_bit_reg <= 1'b0;
            parity_err_reg <= 1'b0;
`endif
        end else begin
            rx_valid    <= 1'b0;
            rx_prev_reg <= rx_sync;
            case (state_reg)
                IDLE: begin
                    baud_cnt_reg <= '0;
                    bit_cnt_reg  <= '0;
                    if (rx_prev_reg && !rx_sync) begin
                        state_reg <= START;
                    end
                end
                START: begin
                    // Half-bit resample rejects glitches and aligns later samples to mid-bit.
                    if (baud_cnt_reg == HALF_LAST) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= rx_sync ? IDLE : DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {rx_sync, shift_reg[DATA_BITS-1:1]};
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= PARITY;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        baud_cnt_reg   <= '0;
                        stop_err_reg   <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
                        parity_bit_reg <= rx_sync;
`endif
                        state_reg      <= STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == STOP_LAST) begin
                            bit_cnt_reg    <= '0;
                            rx_valid       <= 1'b1;
                            rx_data        <= shift_reg;
                            frame_err      <= stop_err_reg | ~rx_sync;
`ifdef RX_PARITY_CHECK_EN
                            parity_err_reg <= ^{shift_reg, parity_bit_reg};
`endif
                            // A low final stop bit means break/stuck line: wait for it to recover.
                            state_reg      <= rx_sync ? IDLE : WAIT_IDLE;
                        end else begin
                            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                            stop_err_reg <= stop_err_reg | ~rx_sync;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_sync) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_uart_receiver.sv
// Self-checking bench for rx_uart_receiver with CLKS_PER_BIT=16, STOP_BITS=2.
module tb_rx_uart_receiver;

    localparam int CPB      = 16;
    localparam int SB       = 2;
    localparam int MID_LAST = 10 * CPB + CPB / 2;
    localparam int LAT_MAX  = CPB / 2 + 3;
`ifdef RX_PARITY_CHECK_EN
    localparam bit PCHK = 1'b1;
`else
    localparam bit PCHK = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic [6:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic [2:0] current_state;

    rx_uart_receiver #(
        .CLKS_PER_BIT  (CPB),
        .STOP_BITS     (SB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_in         (rx_in),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .current_state (current_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] data;
        logic       perr;
        logic       ferr;
        int         t;
    } rec_t;

    rec_t got_q[$];
    always @(negedge clk) begin
        if (rx_valid) begin
            rec_t nr;
            nr.data = rx_data;
            nr.perr = parity_err;
            nr.ferr = frame_err;
            nr.t    = cyc;
            got_q.push_back(nr);
        end
    end

    int vectors = 0;
    int errors  = 0;
    int frame_start = 0;

    // Reference model: a frame's expected status from its bit values alone.
    function automatic logic exp_perr(input logic [6:0] d, input logic p);
        return PCHK ? ((^d) ^ p) : 1'b0;
    endfunction

    function automatic logic exp_ferr(input logic s1, input logic s2);
        return !(s1 && s2);
    endfunction

    task automatic send_frame(input logic [6:0] d, input logic p, input logic s1, input logic s2);
        logic [10:0] bits;
        bits = {s2, s1, p, d, 1'b0};
        frame_start = cyc;
        for (int i = 0; i < 11; i++) begin
            rx_in = bits[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (current_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", current_state); end
        vectors++;
        if ({rx_data, rx_valid, parity_err, frame_err} !== 10'd0) begin
            errors++; $display("FAIL reset_outputs: got data=%h v=%b p=%b f=%b expected all 0", rx_data, rx_valid, parity_err, frame_err);
        end
        reset = 1'b0;
        idle_bits(1);
        vectors++;
        if (got_q.size() != 0) begin errors++; $display("FAIL reset_idle_pulses: got %0d expected 0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_single(input string name, input logic [6:0] d, input logic p);
        rec_t r;
        int lat;
        send_frame(d, p, 1'b1, 1'b1);
        idle_bits(1);
        vectors++;
        if (got_q.size() != 1) begin errors++; $display("FAIL %s_count: got %0d expected 1", name, got_q.size()); end
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            lat = r.t - frame_start - MID_LAST;
            $display("frame %s: sent %02h p=%b -> data=%02h perr=%b ferr=%b lat=%0d", name, d, p, r.data, r.perr, r.ferr, lat);
            vectors++;
            if (r.data !== d) begin errors++; $display("FAIL %s_data: got %02h expected %02h", name, r.data, d); end
            vectors++;
            if (r.perr !== exp_perr(d, p)) begin errors++; $display("FAIL %s_perr: got %b expected %b", name, r.perr, exp_perr(d, p)); end
            vectors++;
            if (r.ferr !== 1'b0) begin errors++; $display("FAIL %s_ferr: got %b expected 0", name, r.ferr); end
            vectors++;
            if (lat < 0 || lat > LAT_MAX) begin errors++; $display("FAIL %s_latency: got %0d expected 0..%0d", name, lat, LAT_MAX); end
        end
        got_q.delete();
    endtask

    task automatic test_glitch;
        rx_in = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (current_state !== 3'd1) begin errors++; $display("FAIL glitch_start_state: got %0d expected 1", current_state); end
        rx_in = 1'b1;
        repeat (7) @(negedge clk);
        vectors++;
        if (current_state !== 3'd0) begin errors++; $display("FAIL glitch_return_idle: got %0d expected 0", current_state); end
        idle_bits(2);
        $display("glitch: 5-cycle low pulse, pulses seen=%0d", got_q.size());
        vectors++;
        if (got_q.size() != 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_frame_err;
        rec_t r;
        send_frame(7'h7F, 1'b1, 1'b1, 1'b0);
        repeat (200) @(negedge clk);
        vectors++;
        if (got_q.size() != 1) begin errors++; $display("FAIL break_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            $display("frame break: sent 7f stop=10 -> data=%02h perr=%b ferr=%b", r.data, r.perr, r.ferr);
            vectors++;
            if (r.data !== 7'h7F) begin errors++; $display("FAIL break_data: got %02h expected 7f", r.data); end
            vectors++;
            if (r.ferr !== exp_ferr(1'b1, 1'b0)) begin errors++; $display("FAIL break_ferr: got %b expected 1", r.ferr); end
            vectors++;
            if (r.perr !== exp_perr(7'h7F, 1'b1)) begin errors++; $display("FAIL break_perr: got %b expected 0", r.perr); end
        end
        vectors++;
        if (current_state !== 3'd5) begin errors++; $display("FAIL break_state: got %0d expected 5", current_state); end
        rx_in = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        vectors++;
        if (current_state !== 3'd0) begin errors++; $display("FAIL break_recover_state: got %0d expected 0", current_state); end
        vectors++;
        if (got_q.size() != 0) begin errors++; $display("FAIL break_extra_pulses: got %0d expected 0", got_q.size()); end
        got_q.delete();
    endtask

    task automatic test_reset_midframe;
        logic [10:0] bits;
        rec_t r;
        bits = {1'b1, 1'b1, ^7'h2A, 7'h2A, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx_in = bits[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = bits[4];
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (current_state !== 3'd0 || rx_data !== 7'd0) begin
            errors++; $display("FAIL abort_reset_state: got state=%0d data=%02h expected 0/00", current_state, rx_data);
        end
        idle_bits(2);
        vectors++;
        if (got_q.size() != 0) begin errors++; $display("FAIL abort_pulses: got %0d expected 0", got_q.size()); end
        got_q.delete();
        send_frame(7'h13, ^7'h13, 1'b1, 1'b1);
        idle_bits(1);
        vectors++;
        if (got_q.size() != 1) begin errors++; $display("FAIL abort_next_count: got %0d expected 1", got_q.size()); end
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            $display("frame after abort: sent 13 -> data=%02h perr=%b ferr=%b", r.data, r.perr, r.ferr);
            vectors++;
            if (r.data !== 7'h13 || r.perr !== 1'b0 || r.ferr !== 1'b0) begin
                errors++; $display("FAIL abort_next_frame: got %02h/%b/%b expected 13/0/0", r.data, r.perr, r.ferr);
            end
        end
        got_q.delete();
    endtask

    task automatic test_back_to_back;
        rec_t r0, r1;
        send_frame(7'h00, 1'b0, 1'b1, 1'b1);
        send_frame(7'h7F, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
        vectors++;
        if (got_q.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", got_q.size()); end
        if (got_q.size() >= 2) begin
            r0 = got_q.pop_front();
            r1 = got_q.pop_front();
            $display("back-to-back: data=%02h,%02h spacing=%0d", r0.data, r1.data, r1.t - r0.t);
            vectors++;
            if (r0.data !== 7'h00 || r1.data !== 7'h7F) begin
                errors++; $display("FAIL b2b_data: got %02h,%02h expected 00,7f", r0.data, r1.data);
            end
            vectors++;
            if (r1.t - r0.t != 11 * CPB) begin errors++; $display("FAIL b2b_spacing: got %0d expected %0d", r1.t - r0.t, 11 * CPB); end
            vectors++;
            if ({r0.perr, r0.ferr, r1.perr, r1.ferr} !== 4'b0000) begin
                errors++; $display("FAIL b2b_status: got %b%b,%b%b expected 00,00", r0.perr, r0.ferr, r1.perr, r1.ferr);
            end
        end
        got_q.delete();
    endtask

    task automatic test_random;
        rec_t r;
        logic [6:0] d;
        logic p, s1, s2;
        int lat;
        for (int n = 0; n < 24; n++) begin
            d  = 7'($urandom_range(0, 127));
            p  = (^d) ^ ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 4) != 0);
            s2 = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s1, s2);
            vectors++;
            if (got_q.size() != 1) begin errors++; $display("FAIL rand%0d_count: got %0d expected 1", n, got_q.size()); end
            if (got_q.size() > 0) begin
                r = got_q.pop_front();
                lat = r.t - frame_start - MID_LAST;
                $display("random %0d: sent %02h p=%b s=%b%b -> data=%02h perr=%b ferr=%b", n, d, p, s1, s2, r.data, r.perr, r.ferr);
                vectors++;
                if (r.data !== d || r.perr !== exp_perr(d, p) || r.ferr !== exp_ferr(s1, s2)) begin
                    errors++;
                    $display("FAIL rand%0d_frame: got %02h/%b/%b expected %02h/%b/%b", n, r.data, r.perr, r.ferr, d, exp_perr(d, p), exp_ferr(s1, s2));
                end
                vectors++;
                if (lat < 0 || lat > LAT_MAX) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 0..%0d", n, lat, LAT_MAX); end
            end
            got_q.delete();
            if (!s2) idle_bits(1);
            else idle_bits($urandom_range(0, 2));
        end
        idle_bits(1);
        vectors++;
        if (got_q.size() != 0) begin errors++; $display("FAIL rand_trailing_pulses: got %0d expected 0", got_q.size()); end
        got_q.delete();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single("0x55", 7'h55, 1'b0);
        test_single("0x41_badpar", 7'h41, 1'b1);
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/rx_uart_receiver.md
RX_UART_RECEIVER -- requirements
Module: rx_uart_receiver

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clk cycles per bit (50 MHz / 9600 baud); legal range >= 4.
REQ-002 Parameter STOP_BITS, default 2, number of stop bits checked (1 or 2).
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_in  input  1  serial line, idle high, asynchronous to clk.
REQ-006 rx_data  output  7  last received data word.
REQ-007 rx_valid  output  1  one-cycle pulse when a frame completes.
REQ-008 parity_err  output  1  parity status of the last frame, valid with rx_valid.
REQ-009 frame_err  output  1  stop-bit status of the last frame, valid with rx_valid.
REQ-010 current_state  output  3  FSM state encoding, for debug LEDs.

Function
REQ-011 Frame format SHALL be: 1 start bit (0), 7 data bits LSB first, 1 even-parity bit, then STOP_BITS stop bits (1).
REQ-012 rx_in SHALL pass through a 2-flop synchroniser before any use; the synchroniser adds 2 cycles of latency.
REQ-013 FSM states: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_IDLE=5.
REQ-014 IDLE -> START on a synchronised falling edge (1 then 0); the baud counter clears.
REQ-015 In START, the line SHALL be resampled at CLKS_PER_BIT/2 cycles: 0 -> DATA with the counter cleared; 1 -> IDLE (glitch rejected, no rx_valid).
REQ-016 DATA, PARITY and STOP SHALL sample the line each time the counter reaches CLKS_PER_BIT-1, i.e. at mid-bit; the counter then wraps to 0.
REQ-017 DATA SHALL shift 7 samples into a holding register, with bit 0 first; a 3-bit counter SHALL move the FSM to PARITY after the 7th sample.
REQ-018 PARITY SHALL capture one sample; error = XOR of the 7 data bits and the parity sample.
REQ-019 STOP SHALL sample STOP_BITS bits; any 0 sets frame_err for this frame.
REQ-020 After the last stop sample, in the same cycle: rx_data <= holding register; parity_err and frame_err update; rx_valid = 1 for exactly one cycle.
REQ-021 Next state after the stop bits: IDLE if the last stop sample was 1; WAIT_IDLE if it was 0 (break or line stuck low).
REQ-022 WAIT_IDLE -> IDLE only after a synchronised 1 is seen, so a held-low line cannot retrigger frames.
REQ-023 rx_data, parity_err and frame_err SHALL hold their values until the next rx_valid.
REQ-024 End-to-end latency: rx_valid asserts within CLKS_PER_BIT/2 + 3 cycles of the mid-point of the last stop bit, as seen at the pins.
REQ-025 A falling edge during WAIT_IDLE SHALL be ignored; back-to-back frames with no idle gap SHALL be received when the last stop bit is 1.
REQ-026 The baud counter width SHALL be $clog2(CLKS_PER_BIT).

Reset
REQ-027 Reset asserted: FSM=IDLE; all counters=0; synchroniser flops=1; rx_data=0; rx_valid=0; parity_err=0; frame_err=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rx_valid; after release, reception resumes only on a new falling edge.

Configuration
REQ-029 Macro RX_PARITY_CHECK_EN defined: parity is checked as in REQ-018.
REQ-030 RX_PARITY_CHECK_EN undefined: the PARITY state is still traversed and its bit consumed, but not checked; parity_err is tied to 0.

Structure
REQ-031 The shared package rx_uart_pkg SHALL hold: the FSM state enum (3-bit), DATA_BITS=7, and the default CLKS_PER_BIT.
REQ-032 The synchroniser SHALL be a sub-module, rx_synchroniser (2 flops, reset to 1); the baud counter, bit counter and FSM stay in rx_uart_receiver.

Verification (CLKS_PER_BIT=16, STOP_BITS=2)
REQ-033 Send 0x55 with parity 0 and 2 stop bits -> one rx_valid pulse; rx_data=0x55; parity_err=0; frame_err=0.
REQ-034 Send 0x41 with parity bit 1 (wrong) -> rx_data=0x41; parity_err=1. With RX_PARITY_CHECK_EN undefined -> parity_err=0.
REQ-035 Drive a 5-cycle low glitch on an idle line -> no rx_valid; current_state returns to 0 within 12 cycles.
REQ-036 Send 0x7F with the second stop bit 0, then hold the line low for 200 cycles -> frame_err=1; state=WAIT_IDLE; no further rx_valid until the line goes high.
REQ-037 Assert reset during data bit 3 of 0x2A, release, then send 0x13 -> no pulse for the aborted frame; single rx_valid with rx_data=0x13.
REQ-038 Send 0x00 then 0x7F back-to-back -> two rx_valid pulses 11*16 cycles apart, with correct data for each.
